// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scanned 7-segment bus and decoded digit outputs
interface seg_scan_decoder_if;
    logic [7:0]  seg;
    logic [3:0]  am0;
    logic [15:0] digits;
    logic [3:0]  dvalid;
    logic [3:0]  dp;
    logic        new_strobe;
    logic [1:0]  new_idx;
    logic [3:0]  new_val;
    logic        err;
    logic [7:0]  err_cnt;

    modport master (
        output seg, am0,
        input  digits, dvalid, dp, new_strobe, new_idx, new_val, err, err_cnt
    );

    modport slave (
        input  seg, am0,
        output digits, dvalid, dp, new_strobe, new_idx, new_val, err, err_cnt
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - debounced decoder for a multiplexed 4-digit 7-segment scan
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic               clk,
    input  logic               reset,
    seg_scan_decoder_if.slave  bus
);
    typedef enum logic {QUALIFY, LOCKED} state_t;

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYC - 1);

    state_t      state_q;
    logic [11:0] s_q;
    logic [7:0]  cnt_q;
    logic [15:0] digits_q;
    logic [3:0]  dvalid_q;
    logic [3:0]  dp_q;
    logic        new_strobe_q;
    logic [1:0]  new_idx_q;
    logic [3:0]  new_val_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;

    logic [11:0] in_d;
    logic        same_d;
    logic        dec_ok_d;
    logic [3:0]  dec_val_d;
    logic        sel_blank_d;
    logic        sel_one_d;
    logic [1:0]  sel_idx_d;
    logic [3:0]  cur_val_d;

    assign in_d      = {bus.am0, bus.seg};
    assign same_d    = (in_d == s_q);
    assign cur_val_d = digits_q[{sel_idx_d, 2'b00} +: 4];

    // Segment lines are active-low; the dp bit is ignored for the digit value.
    always_comb begin
        dec_ok_d  = 1'b1;
        dec_val_d = 4'd0;
        case (s_q[7:1])
            7'b0000001: dec_val_d = 4'd0;
            7'b1001111: dec_val_d = 4'd1;
            7'b0010010: dec_val_d = 4'd2;
            7'b0000110: dec_val_d = 4'd3;
            7'b1001100: dec_val_d = 4'd4;
            7'b0100100: dec_val_d = 4'd5;
            7'b1100000: dec_val_d = 4'd6;
            7'b0001111: dec_val_d = 4'd7;
            7'b0000000: dec_val_d = 4'd8;
            7'b0001100: dec_val_d = 4'd9;
            default:    dec_ok_d  = 1'b0;
        endcase
    end

    always_comb begin
        sel_blank_d = 1'b0;
        sel_one_d   = 1'b1;
        sel_idx_d   = 2'd0;
        case (s_q[11:8])
            4'b1110: sel_idx_d   = 2'd0;
            4'b1101: sel_idx_d   = 2'd1;
            4'b1011: sel_idx_d   = 2'd2;
            4'b0111: sel_idx_d   = 2'd3;
            4'b1111: begin
                sel_blank_d = 1'b1;
                sel_one_d   = 1'b0;
            end
            default: sel_one_d   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= QUALIFY;
            s_q          <= 12'hFFF;
            cnt_q        <= 8'd0;
            digits_q     <= 16'd0;
            dvalid_q     <= 4'd0;
            dp_q         <= 4'd0;
            new_strobe_q <= 1'b0;
            new_idx_q    <= 2'd0;
            new_val_q    <= 4'd0;
            err_q        <= 1'b0;
            err_cnt_q    <= 8'd0;
        end else begin
            s_q          <= in_d;
            new_strobe_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                QUALIFY: begin
                    if (!same_d) begin
                        cnt_q <= 8'd0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_q <= LOCKED;
                        // Accept the stable pattern held in s_q.
                        if (!sel_blank_d) begin
                            if (!sel_one_d || !dec_ok_d) begin
                                err_q <= 1'b1;
                                if (err_cnt_q != 8'hFF) begin
                                    err_cnt_q <= err_cnt_q + 8'd1;
                                end
                            end
                            if (sel_one_d) begin
                                dp_q[sel_idx_d] <= ~s_q[0];
                                if (!dec_ok_d) begin
                                    dvalid_q[sel_idx_d] <= 1'b0;
                                end else begin
                                    digits_q[{sel_idx_d, 2'b00} +: 4] <= dec_val_d;
                                    dvalid_q[sel_idx_d] <= 1'b1;
                                    if (!dvalid_q[sel_idx_d] || cur_val_d != dec_val_d) begin
                                        new_strobe_q <= 1'b1;
                                        new_idx_q    <= sel_idx_d;
                                        new_val_q    <= dec_val_d;
                                    end
                                end
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                LOCKED: begin
                    if (!same_d) begin
                        state_q <= QUALIFY;
                        cnt_q   <= 8'd0;
                    end
                end
                default: state_q <= QUALIFY;
            endcase
        end
    end

    assign bus.digits     = digits_q;
    assign bus.dvalid     = dvalid_q;
    assign bus.dp         = dp_q;
    assign bus.new_strobe = new_strobe_q;
    assign bus.new_idx    = new_idx_q;
    assign bus.new_val    = new_val_q;
    assign bus.err        = err_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - randomized model-based bench for seg_scan_decoder
module tb_seg_scan_decoder;
    localparam int SC = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(.STABLE_CYC(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a pattern is accepted when it is the (SC+1)th consecutive identical sample.
    logic [6:0]  pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b1100000, 7'b0001111, 7'b0000000, 7'b0001100};
    int          run;
    logic [11:0] prev;
    logic [3:0]  m_dig [4];
    logic [3:0]  m_v;
    logic [3:0]  m_dp;
    logic        m_str;
    logic        m_err;
    logic [1:0]  m_idx;
    logic [3:0]  m_val;
    int          m_cnt;

    function automatic int decode(input logic [6:0] s);
        int v;
        v = -1;
        for (int i = 0; i < 10; i++) if (pat[i] == s) v = i;
        return v;
    endfunction

    function automatic logic [39:0] exp_vec();
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_v, m_dp, m_str, m_idx, m_val, m_err, 8'(m_cnt)};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {bus.digits, bus.dvalid, bus.dp, bus.new_strobe, bus.new_idx, bus.new_val, bus.err, bus.err_cnt};
    endfunction

    task automatic model_reset();
        run  = 1;
        prev = 12'hFFF;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
        m_v = 0; m_dp = 0; m_str = 0; m_err = 0; m_idx = 0; m_val = 0; m_cnt = 0;
    endtask

    task automatic model_accept(input logic [3:0] a, input logic [7:0] s);
        int zeros;
        int k;
        int v;
        zeros = 0;
        k = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; k = i; end
        v = decode(s[7:1]);
        if (zeros > 1 || (zeros == 1 && v < 0)) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
        end
        if (zeros == 1) begin
            m_dp[k] = ~s[0];
            if (v < 0) begin
                m_v[k] = 1'b0;
            end else begin
                if (!m_v[k] || m_dig[k] != 4'(v)) begin
                    m_str = 1;
                    m_idx = 2'(k);
                    m_val = 4'(v);
                end
                m_dig[k] = 4'(v);
                m_v[k]   = 1'b1;
            end
        end
    endtask

    task automatic clk_step(input logic [3:0] a, input logic [7:0] s);
        bus.am0 = a;
        bus.seg = s;
        @(posedge clk);
        m_str = 0;
        m_err = 0;
        if ({a, s} == prev) run++; else run = 1;
        prev = {a, s};
        if (run == SC + 1) model_accept(a, s);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.am0 = 4'hF;
        bus.seg = 8'hFF;
        do_reset();
        checks++;
        if (dut_vec() !== 40'd0) begin
            errors++;
            $display("FAIL reset_state got %h exp 0", dut_vec());
        end
    endtask

    task automatic test_first_accept();
        int ns;
        ns = 0;
        for (int e = 1; e <= 100; e++) begin
            clk_step(4'd14, 8'b00100101);
            ns += int'(bus.new_strobe);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL first_accept_model edge %0d got %h exp %h", e, dut_vec(), exp_vec());
            end
            if (e < 5) begin
                checks++;
                if (bus.new_strobe !== 1'b0 || bus.dvalid !== 4'b0000) begin
                    errors++;
                    $display("FAIL early_accept edge %0d got strobe %b dvalid %b exp 0 0000", e, bus.new_strobe, bus.dvalid);
                end
            end
            if (e == 5) begin
                checks++;
                if ({bus.digits[3:0], bus.dvalid, bus.new_strobe, bus.new_idx, bus.new_val} !== {4'd2, 4'b0001, 1'b1, 2'd0, 4'd2}) begin
                    errors++;
                    $display("FAIL edge5_accept got dig %h dv %b st %b idx %0d val %0d exp 2 0001 1 0 2",
                             bus.digits[3:0], bus.dvalid, bus.new_strobe, bus.new_idx, bus.new_val);
                end
            end
        end
        checks++;
        if (ns !== 1) begin
            errors++;
            $display("FAIL hold_strobe_count got %0d exp 1", ns);
        end
        ns = 0;
        for (int e = 0; e < 10; e++) begin
            clk_step(4'd14, 8'b00100100);
            ns += int'(bus.new_strobe);
        end
        checks++;
        if (bus.dp[0] !== 1'b1 || ns !== 0 || bus.digits[3:0] !== 4'd2) begin
            errors++;
            $display("FAIL dp_update got dp %b strobes %0d dig %0d exp 1 0 2", bus.dp[0], ns, bus.digits[3:0]);
        end
    endtask

    task automatic test_glitch();
        logic [39:0] snap;
        int ev;
        snap = dut_vec();
        ev = 0;
        for (int e = 0; e < 3; e++) begin
            clk_step(4'd13, 8'b10011111);
            ev += int'(bus.new_strobe) + int'(bus.err);
        end
        for (int e = 0; e < 8; e++) begin
            clk_step(4'hF, 8'hFF);
            ev += int'(bus.new_strobe) + int'(bus.err);
        end
        checks++;
        if (dut_vec() !== snap || ev !== 0) begin
            errors++;
            $display("FAIL glitch_reject got %h events %0d exp %h 0", dut_vec(), ev, snap);
        end
    endtask

    task automatic test_illegal_seg();
        int ne;
        do_reset();
        clk_step(4'd11, 8'b00000011);
        for (int e = 0; e < 8; e++) clk_step(4'd11, 8'b00000011);
        ne = 0;
        for (int e = 0; e < 10; e++) begin
            clk_step(4'd11, 8'hFF);
            ne += int'(bus.err);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL illegal_model got %h exp %h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (ne !== 1 || bus.err_cnt !== 8'd1 || bus.dvalid[2] !== 1'b0 || bus.digits[11:8] !== 4'd0) begin
            errors++;
            $display("FAIL illegal_seg got errs %0d cnt %0d dv2 %b dig2 %0d exp 1 1 0 0",
                     ne, bus.err_cnt, bus.dvalid[2], bus.digits[11:8]);
        end
    endtask

    task automatic test_multi_zero();
        logic [19:0] snap;
        int bad;
        snap = {bus.digits, bus.dvalid};
        bad = 0;
        for (int n = 0; n < 300; n++) begin
            for (int e = 0; e < SC + 1; e++) begin
                clk_step(4'b1100, n[0] ? 8'b00100101 : 8'b10011111);
                if (dut_vec() !== exp_vec() || bus.new_strobe === 1'b1) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL multi_zero_model got %0d bad cycles exp 0", bad);
        end
        checks++;
        if (bus.err_cnt !== 8'd255 || {bus.digits, bus.dvalid} !== snap) begin
            errors++;
            $display("FAIL multi_zero_sat got cnt %0d dig/dv %h exp 255 %h", bus.err_cnt, {bus.digits, bus.dvalid}, snap);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] an [4] = '{4'd14, 4'd13, 4'd11, 4'd7};
        int         vl [4] = '{1, 3, 5, 9};
        for (int d = 0; d < 4; d++)
            for (int e = 0; e < 8; e++) clk_step(an[d], {pat[vl[d]], 1'b1});
        checks++;
        if (bus.digits !== 16'h9531 || bus.dvalid !== 4'b1111) begin
            errors++;
            $display("FAIL rotation got %h %b exp 9531 1111", bus.digits, bus.dvalid);
        end
        for (int e = 0; e < 6; e++) clk_step(an[0], {pat[7], 1'b0});
        for (int e = 0; e < 3; e++) clk_step(an[1], {pat[8], 1'b1});
        reset = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 40'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp 0", dut_vec());
        end
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        for (int e = 0; e < SC + 1; e++) begin
            clk_step(an[1], {pat[8], 1'b1});
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL post_reset_qualify edge %0d got %h exp %h", e, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [7:0] s;
        int hold;
        int r;
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) a = (4'hF & ~(4'd1 << $urandom_range(0, 3)));
            else if (r < 8) a = 4'hF;
            else a = 4'($urandom);
            if ($urandom_range(0, 9) < 7) s = {pat[$urandom_range(0, 9)], 1'($urandom)};
            else s = 8'($urandom);
            hold = int'($urandom_range(1, 8));
            for (int e = 0; e < hold; e++) begin
                clk_step(a, s);
                checks++;
                if (dut_vec() !== exp_vec() || (bus.err === 1'b1 && bus.new_strobe === 1'b1)) begin
                    errors++;
                    $display("FAIL random step %0d got %h exp %h", n, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        model_reset();
        test_reset();
        test_first_accept();
        test_glitch();
        test_illegal_seg();
        test_multi_zero();
        test_rotation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
